button_emulator: RTL and testbench



---
 rtl/button_emulator.sv | 171 +++++++++++++++++
 tb/tb_button_emulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/button_emulator.sv
// ============================================================================
// button_emulator : bouncing push-button generator (press bounce, hold, release bounce)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module button_emulator #(
    parameter int          GAP_RANDOM = 1,
    parameter int          GAP_FIXED  = 2,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        press_req,
    input  logic [15:0] hold_cycles,
    input  logic [3:0]  bounce_cnt,
    output logic        button,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS_B = 3'd1,
        S_HOLD    = 3'd2,
        S_REL_B   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] C_GAP_FIXED = 4'(GAP_FIXED);

    state_t      state_q, state_d;
    logic        button_q, button_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  nb_q, nb_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  gw_q, gw_d;
    logic        half_q, half_d;

    logic [7:0]  lfsr_next;
    logic [3:0]  gap_draw;
    logic [15:0] hold_last;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign gap_draw  = (GAP_RANDOM != 0) ? ({2'b00, lfsr_q[1:0]} + 4'd1) : C_GAP_FIXED;
    // Hold counter counts down to zero, so load H-1 with a zero request meaning one cycle.
    assign hold_last = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            button_q <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            hold_q   <= '0;
            nb_q     <= '0;
            hcnt_q   <= '0;
            gcnt_q   <= '0;
            wcnt_q   <= '0;
            gw_q     <= '0;
            half_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            button_q <= button_d;
            lfsr_q   <= lfsr_d;
            hold_q   <= hold_d;
            nb_q     <= nb_d;
            hcnt_q   <= hcnt_d;
            gcnt_q   <= gcnt_d;
            wcnt_q   <= wcnt_d;
            gw_q     <= gw_d;
            half_q   <= half_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        button_d = button_q;
        lfsr_d   = lfsr_q;
        hold_d   = hold_q;
        nb_d     = nb_q;
        hcnt_d   = hcnt_q;
        gcnt_d   = gcnt_q;
        wcnt_d   = wcnt_q;
        gw_d     = gw_q;
        half_d   = half_q;

        unique case (state_q)
            S_IDLE: begin
                button_d = 1'b0;
                if (press_req) begin
                    hold_d   = hold_cycles;
                    nb_d     = bounce_cnt;
                    button_d = 1'b1;
                    if (bounce_cnt != 4'd0) begin
                        state_d = S_PRESS_B;
                        gcnt_d  = bounce_cnt - 4'd1;
                        gw_d    = gap_draw;
                        wcnt_d  = gap_draw - 4'd1;
                        half_d  = 1'b0;
                        lfsr_d  = lfsr_next;
                    end else begin
                        state_d = S_HOLD;
                        hcnt_d  = (hold_cycles == 16'd0) ? 16'd0 : hold_cycles - 16'd1;
                    end
                end
            end

            // Both bounce phases share one engine; the second half of a glitch is the inverted level.
            S_PRESS_B, S_REL_B: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (!half_q) begin
                    half_d   = 1'b1;
                    button_d = ~button_q;
                    wcnt_d   = gw_q - 4'd1;
                end else if (gcnt_q != 4'd0) begin
                    gcnt_d   = gcnt_q - 4'd1;
                    gw_d     = gap_draw;
                    wcnt_d   = gap_draw - 4'd1;
                    half_d   = 1'b0;
                    lfsr_d   = lfsr_next;
                    button_d = ~button_q;
                end else if (state_q == S_PRESS_B) begin
                    state_d  = S_HOLD;
                    button_d = 1'b1;
                    hcnt_d   = hold_last;
                end else begin
                    state_d  = S_DONE;
                    button_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (hcnt_q != 16'd0) begin
                    hcnt_d = hcnt_q - 16'd1;
                end else if (nb_q != 4'd0) begin
                    state_d  = S_REL_B;
                    button_d = 1'b0;
                    gcnt_d   = nb_q - 4'd1;
                    gw_d     = gap_draw;
                    wcnt_d   = gap_draw - 4'd1;
                    half_d   = 1'b0;
                    lfsr_d   = lfsr_next;
                end else begin
                    state_d  = S_DONE;
                    button_d = 1'b0;
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                button_d = 1'b0;
            end

            default: begin
                state_d  = S_IDLE;
                button_d = 1'b0;
            end
        endcase
    end

    assign button = button_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_button_emulator.sv
// ============================================================================
// tb_button_emulator : fixed-gap and random-gap instances checked cycle by cycle
// against a waveform model built from the press/hold/release rules.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_emulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        press_req = 1'b0;
    logic [15:0] hold_cycles = '0;
    logic [3:0]  bounce_cnt = '0;
    logic        button_f, busy_f, done_f;
    logic        button_r, busy_r, done_r;

    int errors = 0;
    int checks = 0;

    logic [7:0] lf_ref = 8'hA5;
    bit         exp_f[$];
    bit         exp_r[$];
    int         press_len_r;

    typedef struct {
        int n;
        int h;
        bit inj;
        int len;
        int hi;
    } vec_t;
    vec_t tbl[7];

    button_emulator #(.GAP_RANDOM(0), .GAP_FIXED(2), .LFSR_SEED(8'hA5)) u_fix (
        .clk(clk), .rst_n(rst_n), .press_req(press_req), .hold_cycles(hold_cycles),
        .bounce_cnt(bounce_cnt), .button(button_f), .busy(busy_f), .done(done_f)
    );

    button_emulator #(.GAP_RANDOM(1), .GAP_FIXED(2), .LFSR_SEED(8'hA5)) u_rnd (
        .clk(clk), .rst_n(rst_n), .press_req(press_req), .hold_cycles(hold_cycles),
        .bounce_cnt(bounce_cnt), .button(button_r), .busy(busy_r), .done(done_r)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int draw();
        int g;
        g = 1 + int'(lf_ref[1:0]);
        lf_ref = {lf_ref[6:0], lf_ref[7] ^ lf_ref[5] ^ lf_ref[4] ^ lf_ref[3]};
        return g;
    endfunction

    task automatic push_run(input bit rnd, input bit v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (rnd) exp_r.push_back(v);
            else     exp_f.push_back(v);
        end
    endtask

    task automatic build(input int n, input int h);
        int hh;
        int g;
        hh = (h == 0) ? 1 : h;
        exp_f.delete();
        exp_r.delete();
        for (int i = 0; i < n; i++) begin
            push_run(0, 1'b1, 2); push_run(0, 1'b0, 2);
        end
        push_run(0, 1'b1, hh);
        for (int i = 0; i < n; i++) begin
            push_run(0, 1'b0, 2); push_run(0, 1'b1, 2);
        end
        push_run(0, 1'b0, 1);
        for (int i = 0; i < n; i++) begin
            g = draw();
            push_run(1, 1'b1, g); push_run(1, 1'b0, g);
        end
        press_len_r = exp_r.size();
        push_run(1, 1'b1, hh);
        for (int i = 0; i < n; i++) begin
            g = draw();
            push_run(1, 1'b0, g); push_run(1, 1'b1, g);
        end
        push_run(1, 1'b0, 1);
    endtask

    // Called in the cycle before E0; returns in the first idle cycle of the longer instance.
    task automatic run_seq(input int n, input int h, input bit inj, input bit abort,
                           output int busy_len, output int hi_cnt);
        int lenf, lenr, kmax, abort_k;
        bit do_inj;
        build(n, h);
        lenf = exp_f.size();
        lenr = exp_r.size();
        do_inj  = inj && (lenf >= 5) && (lenr >= 5);
        abort_k = abort ? press_len_r + 2 : 0;
        kmax = ((lenf > lenr) ? lenf : lenr) + 1;
        busy_len = 0;
        hi_cnt   = 0;
        bounce_cnt  = 4'(n);
        hold_cycles = 16'(h);
        press_req   = 1'b1;
        @(posedge clk); #1;
        press_req = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            busy_len += int'(busy_f);
            hi_cnt   += int'(button_f);
            if (k <= lenf) begin
                check("fix_button", button_f, exp_f[k-1]);
                check("fix_busy", busy_f, 1);
                check("fix_done", done_f, (k == lenf));
            end else if (k == lenf + 1) begin
                check("fix_idle_busy", busy_f, 0);
                check("fix_idle_button", button_f, 0);
            end
            if (k <= lenr) begin
                check("rnd_button", button_r, exp_r[k-1]);
                check("rnd_busy", busy_r, 1);
                check("rnd_done", done_r, (k == lenr));
            end else if (k == lenr + 1) begin
                check("rnd_idle_busy", busy_r, 0);
                check("rnd_idle_button", button_r, 0);
            end
            if (k == abort_k) begin
                #5 rst_n = 1'b0;
                #1;
                check("abort_fix_button", button_f, 0);
                check("abort_rnd_button", button_r, 0);
                check("abort_rnd_busy", busy_r, 0);
                repeat (2) begin
                    @(posedge clk); #1;
                    check("abort_fix_done", done_f, 0);
                    check("abort_rnd_done", done_r, 0);
                end
                @(negedge clk);
                rst_n  = 1'b1;
                lf_ref = 8'hA5;
                return;
            end
            if (do_inj && k == 3) begin
                press_req   = 1'b1;
                hold_cycles = 16'($urandom);
                bounce_cnt  = 4'($urandom);
            end
            if (do_inj && k == 4) press_req = 1'b0;
        end
    endtask

    initial begin
        int bl, hc;
        tbl[0] = '{n: 0,  h: 5, inj: 0, len: 6,   hi: 5};
        tbl[1] = '{n: 2,  h: 4, inj: 1, len: 21,  hi: 12};
        tbl[2] = '{n: 0,  h: 0, inj: 0, len: 2,   hi: 1};
        tbl[3] = '{n: 1,  h: 3, inj: 1, len: 12,  hi: 7};
        tbl[4] = '{n: 3,  h: 1, inj: 0, len: 26,  hi: 13};
        tbl[5] = '{n: 15, h: 2, inj: 1, len: 123, hi: 62};
        tbl[6] = '{n: 1,  h: 0, inj: 0, len: 10,  hi: 5};

        rst_n       = 1'b0;
        press_req   = 1'b1;
        bounce_cnt  = 4'd0;
        hold_cycles = 16'd5;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_button", button_f | button_r, 0);
            check("rst_busy", busy_f | busy_r, 0);
            check("rst_done", done_f | done_r, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(0, 5, 0, 0, bl, hc);
        check("post_reset_busy_len", bl, 6);

        foreach (tbl[i]) begin
            run_seq(tbl[i].n, tbl[i].h, tbl[i].inj, 0, bl, hc);
            check("tbl_busy_len", bl, tbl[i].len);
            check("tbl_high_cycles", hc, tbl[i].hi);
        end

        for (int i = 0; i < 8; i++) begin
            run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 9)),
                    bit'($urandom_range(0, 1)), 0, bl, hc);
        end

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        lf_ref = 8'hA5;
        run_seq(3, 8, 0, 0, bl, hc);
        run_seq(3, 8, 0, 1, bl, hc);
        run_seq(3, 8, 0, 0, bl, hc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
